// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame sizing, parity and frame building.
// Defining UART_TX_TWO_STOP_EN gives every transmitted frame two stop bits.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

`ifdef UART_TX_TWO_STOP_EN
  localparam logic [3:0] STOP_BITS = 4'd2;
`else
  localparam logic [3:0] STOP_BITS = 4'd1;
`endif

  localparam int unsigned FRAME_W = 32'd12;
  // Start bit plus seven data bits plus the stop bit(s).
  localparam logic [3:0] FRAME_LEN_MIN = 4'd8 + STOP_BITS;

  function automatic logic parity(input logic [7:0] data, input logic eight, input logic ohel);
    return (^data[6:0]) ^ (eight & data[7]) ^ ohel;
  endfunction

  function automatic logic [3:0] frame_len(input logic eight, input logic pen);
    return FRAME_LEN_MIN + {3'b000, eight} + {3'b000, pen};
  endfunction

  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data, input logic eight,
                                                     input logic pen, input logic ohel);
    logic [FRAME_W-1:0] f;
    f      = {FRAME_W{1'b1}};
    f[0]   = 1'b0;
    f[7:1] = data[6:0];
    if (eight) begin
      f[8] = data[7];
      f[9] = pen ? parity(data, eight, ohel) : 1'b1;
    end else begin
      f[8] = pen ? parity(data, eight, ohel) : 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..k-1 while enabled and pulses done_o on the last count.
module uart_bit_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] k_i,
  input  logic        load_i,
  input  logic        en_i,
  output logic        done_o
);

  logic [19:0] k_q, k_d;
  logic [19:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == (k_q - 20'd1));

  // Next-state: a load latches k (0 behaves as 1) and restarts the count.
  always_comb begin
    k_d   = k_q;
    cnt_d = cnt_q;
    if (load_i) begin
      k_d   = (k_i == 20'd0) ? 20'd1 : k_i;
      cnt_d = 20'd0;
    end else if (done_o) begin
      cnt_d = 20'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 20'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= 20'd0;
      cnt_q <= 20'd0;
    end else begin
      k_q   <= k_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: bus-written holding register feeding an LSB-first shifter on Tx.
// Define UART_TX_TWO_STOP_EN (see uart_pkg) for two stop bits per frame.
module uart_transmit
  import uart_pkg::*;
#(
  parameter logic [15:0] PORT_ADDR = 16'h0000,
  parameter int unsigned WR_BIT    = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] k,
  input  logic [15:0] port_id,
  input  logic [15:0] writes,
  input  logic [7:0]  out_port,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  output logic        Tx,
  output logic        TxRdy
);

  logic [1:0]         state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               rdy_q, rdy_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0]         bits_q, bits_d;
  logic               tx_q, tx_d;
  logic               wr_s, load_s, tmr_en_s, tmr_done_s;

  assign wr_s = writes[WR_BIT] && (port_id == PORT_ADDR) && rdy_q;

  uart_bit_timer u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .k_i    (k),
    .load_i (load_s),
    .en_i   (tmr_en_s),
    .done_o (tmr_done_s)
  );

  // Next-state logic for holding register, FSM and shifter.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rdy_d    = rdy_q;
    shift_d  = shift_q;
    bits_d   = bits_q;
    load_s   = 1'b0;
    tmr_en_s = 1'b0;
    if (wr_s) begin
      hold_d = out_port;
      rdy_d  = 1'b0;
    end else begin
      hold_d = hold_q;
    end
    case (state_q)
      ST_IDLE: begin
        shift_d = {FRAME_W{1'b1}};
        state_d = rdy_q ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        load_s = 1'b1;
      end
      ST_SHIFT: begin
        tmr_en_s = 1'b1;
        if (tmr_done_s && (bits_q == 4'd1)) begin
          // Reloading on the stop-bit edge keeps a back-to-back stop bit at exactly k clocks.
          if (!rdy_q) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            shift_d = {FRAME_W{1'b1}};
            bits_d  = 4'd0;
          end
        end else if (tmr_done_s) begin
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          bits_d  = bits_q - 4'd1;
        end else begin
          shift_d = shift_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = {FRAME_W{1'b1}};
      end
    endcase
    if (load_s) begin
      shift_d = build_frame(hold_q, eight, pen, ohel);
      bits_d  = frame_len(eight, pen);
      rdy_d   = 1'b1;
      state_d = ST_SHIFT;
    end else begin
      state_d = state_d;
    end
    tx_d = shift_d[0];
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'h00;
      rdy_q   <= 1'b1;
      shift_q <= {FRAME_W{1'b0}};
      bits_q  <= 4'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rdy_q   <= rdy_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
    end
  end

  assign Tx    = tx_q;
  assign TxRdy = rdy_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Scoreboard bench for uart_transmit: writes push expected frames, a line monitor checks them.
module tb_uart_transmit;

  localparam logic [15:0] ADDR = 16'h0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] k;
  logic [15:0] port_id, writes;
  logic [7:0]  out_port;
  logic        eight, pen, ohel;
  logic        Tx, TxRdy;

  typedef struct {
    logic [7:0]  data;
    logic        eight;
    logic        pen;
    logic        ohel;
    int          k;
  } frame_t;

  frame_t exp_q[$];
  int n_checks    = 0;
  int n_errors    = 0;
  int frames_done = 0;
  int stop_end    = 0;
  int last_gap    = 0;
  int last_len    = 0;
  int nstop       = 1;

  always #5 clk = ~clk;

  uart_transmit #(.PORT_ADDR(ADDR), .WR_BIT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .k        (k),
    .port_id  (port_id),
    .writes   (writes),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .Tx       (Tx),
    .TxRdy    (TxRdy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled at the following posedge.
  task automatic bus_write(input logic [7:0] d, input logic [15:0] addr, input bit accept);
    frame_t f;
    port_id  = addr;
    out_port = d;
    writes   = 16'h0008;
    if (accept) begin
      f.data = d; f.eight = eight; f.pen = pen; f.ohel = ohel; f.k = int'(k);
      exp_q.push_back(f);
    end
    @(negedge clk);
    writes  = 16'h0000;
    port_id = 16'h0000;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frame_timeout", int'(frames_done >= target), 1);
  endtask

  // Line monitor: every bit must hold its expected level for exactly k samples.
  initial begin : monitor
    frame_t     f;
    logic [11:0] eb;
    logic        par;
    int          nb, ones, t0, pp;
    bit          abort;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && Tx === 1'b0) begin
        t0       = int'($time / 10);
        last_gap = t0 - stop_end - 1;
        check("exp_queue", int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) begin
          repeat (200) @(negedge clk);
        end else begin
          f     = exp_q.pop_front();
          eb    = 12'hFFF;
          eb[0] = 1'b0;
          par   = f.ohel;
          for (int i = 0; i < 8; i++) begin
            if (i < 7 || f.eight) begin
              eb[i+1] = f.data[i];
              par     = par ^ f.data[i];
            end
          end
          pp = f.eight ? 9 : 8;
          if (f.pen) eb[pp] = par;
          nb    = 1 + (f.eight ? 8 : 7) + (f.pen ? 1 : 0) + nstop;
          abort = 1'b0;
          for (int b = 0; b < nb && !abort; b++) begin
            ones = 0;
            for (int j = 0; j < f.k && !abort; j++) begin
              if (b != 0 || j != 0) @(negedge clk);
              if (reset !== 1'b1) abort = 1'b1;
              else ones += (Tx === 1'b1) ? 1 : 0;
            end
            if (!abort) check($sformatf("data%02h_bit%0d", f.data, b), ones, eb[b] ? f.k : 0);
          end
          if (!abort) begin
            stop_end = int'($time / 10);
            last_len = stop_end - t0 + 1;
            frames_done++;
          end
        end
      end
    end
  end

  initial begin
`ifdef UART_TX_TWO_STOP_EN
    nstop = 2;
`else
    nstop = 1;
`endif
    reset = 1'b0; k = 20'd4; port_id = 16'h0000; writes = 16'h0000;
    out_port = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(Tx), 1);
    check("reset_rdy", int'(TxRdy), 1);
    reset = 1'b1;
    @(negedge clk);

    // Basic 8-bit odd-parity frame; controls changed mid-frame must not matter.
    k = 20'd109; eight = 1'b1; pen = 1'b1; ohel = 1'b1;
    bus_write(8'hA5, ADDR, 1'b1);
    check("rdy_after_wr_1", int'(TxRdy), 0);
    @(negedge clk);
    check("rdy_after_wr_2", int'(TxRdy), 0);
    @(negedge clk);
    check("rdy_after_wr_3", int'(TxRdy), 1);
    check("start_latency", int'(Tx), 0);
    k = 20'd5; eight = 1'b0; pen = 1'b0;
    wait_frames(1, 1600);

    // 7-bit, no parity.
    @(negedge clk);
    k = 20'd4; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
    bus_write(8'hFF, ADDR, 1'b1);
    wait_frames(2, 200);
    check("len_7bit", last_len, (8 + nstop) * 4);
    @(negedge clk);
    check("idle_after_7bit", int'(Tx), 1);

    // Back-to-back frames.
    eight = 1'b1;
    bus_write(8'h55, ADDR, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_rdy", int'(TxRdy), 1);
    bus_write(8'h0F, ADDR, 1'b1);
    wait_frames(4, 300);
    check("b2b_gap", last_gap, 0);

    // Write while busy and write to another address are dropped.
    @(negedge clk);
    bus_write(8'h11, ADDR, 1'b1);
    bus_write(8'h22, ADDR, 1'b0);
    wait_frames(5, 200);
    @(negedge clk);
    bus_write(8'h33, 16'h0041, 1'b0);
    repeat (80) @(negedge clk);
    check("no_extra_frame", frames_done, 5);
    check("queue_empty", exp_q.size(), 0);

    // Reset during D3 of 8'hF0 (D3 = 0), then a clean frame.
    k = 20'd8; eight = 1'b1; pen = 1'b0;
    bus_write(8'hF0, ADDR, 1'b1);
    repeat (36) @(negedge clk);
    check("pre_reset_tx", int'(Tx), 0);
    #2 reset = 1'b0;
    #1;
    check("midreset_tx", int'(Tx), 1);
    check("midreset_rdy", int'(TxRdy), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_write(8'h3C, ADDR, 1'b1);
    wait_frames(6, 300);
    check("after_reset_len", last_len, (9 + nstop) * 8);

    // Even parity, back-to-back so the stop-bit span before the next start is visible.
    @(negedge clk);
    k = 20'd4; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    bus_write(8'h03, ADDR, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus_write(8'hC3, ADDR, 1'b1);
    wait_frames(8, 300);
    check("par_b2b_gap", last_gap, 0);
    check("par_len", last_len, (10 + nstop) * 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- Serial UART transmitter; the transmit-side counterpart of the UART receiver.
- It shares the receiver's baud count `k` and its frame controls `eight`, `pen` and `ohel`.
- The processor bus writes a byte via `port_id`/`writes`. A one-byte holding register feeds a shift register that drives the `Tx` line LSB first.
- `TxRdy` tells the processor the holding register is free.

Parameters:
- PORT_ADDR, 16'h0000: `port_id` value that selects this block.
- WR_BIT, 0: index of the `writes` strobe bit used as the write enable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- k  in  20  clocks per bit; sampled at frame start.
- port_id  in  16  bus address.
- writes  in  16  one-hot write strobes.
- out_port  in  8  write data.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits; sampled at frame start.
- pen  in  1  parity enable; sampled at frame start.
- ohel  in  1  1 = odd parity, 0 = even parity; sampled at frame start.
- Tx  out  1  serial line; idles high.
- TxRdy  out  1  holding register empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Tx=1, TxRdy=1, state IDLE.
  - Holding register, shifter, bit timer and bit counter all cleared.
  - Reset asserted mid-frame aborts the frame immediately; Tx returns to 1.
- Write accept:
  - Condition: `writes[WR_BIT]` && `port_id==PORT_ADDR` && TxRdy=1 at a rising edge.
  - Effect: `out_port` is captured into the holding register and TxRdy=0 after that edge.
  - A write while TxRdy=0 is ignored; the held data is unchanged.
- Frame format, in transmit order:
  - Start bit 0.
  - D0..D6, plus D7 if eight=1.
  - Parity bit if pen=1: XOR of the transmitted data bits, inverted when ohel=1.
  - Stop bit 1.
  - Frame length is 9, 10 or 11 bits.
- States:
  - IDLE: Tx=1. If the holding register is full, go to LOAD next edge.
  - LOAD (1 cycle):
    - Shifter <= frame built from the holding register and current eight/pen/ohel.
    - Latch k; a k value of 0 is treated as 1.
    - Bit count <= frame length; bit timer <= 0.
    - Holding register marked empty (TxRdy=1 after this edge).
    - Go to SHIFT; Tx = start bit from this edge on.
  - SHIFT:
    - Bit timer counts 0..k-1.
    - When timer==k-1: shift right filling with 1, decrement bit count, timer <= 0.
    - When the last (stop) bit completes: go to LOAD if the holding register is full (back-to-back frame, no idle gap), else go to IDLE.
- Latency:
  - Write accepted at edge N with the block IDLE: LOAD at edge N+1, start bit on Tx after N+2, TxRdy=1 after N+2.
  - Each bit lasts exactly k clocks; the stop bit lasts k clocks before the next start.
- Simultaneous events:
  - A write and a holding-to-shifter transfer can never coincide, because TxRdy=0 while the holding register is full.
  - A write in the same cycle as the stop bit completing is accepted normally.
- Control changes:
  - Changes to k, eight, pen or ohel mid-frame have no effect until the next LOAD.
- Tx is registered, with no combinational path from inputs.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: every frame carries two stop bits (frame length 10–12), and back-to-back frames keep both stop bits.
- Undefined: exactly one stop bit per frame, as described above.

Decomposition:
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, LOAD, SHIFT);
  - the frame-length constants;
  - a `parity(data, eight, ohel)` function, also used by the receiver.
- One natural sub-module, `uart_bit_timer`: a 20-bit counter with load k, enable, and a 1-cycle `done` pulse at k-1.
  - The receiver reuses it with a k_div2 mid-bit variant.

Test Plan:
- Basic frame: k=109, eight=1, pen=1, ohel=1; write 8'hA5.
  - Tx sequence 0,1,0,1,0,0,1,0,1,1(odd parity),1, each bit exactly 109 clocks.
  - TxRdy low for 2 clocks after the write, then high.
- 7-bit, no parity: eight=0, pen=0, k=4; write 8'hFF.
  - 9-bit frame 0,1,1,1,1,1,1,1,1.
  - D7 not sent; total 36 clocks low-to-idle.
- Back-to-back: k=4; write 8'h55, then 8'h0F as soon as TxRdy=1.
  - Second start bit immediately follows the first stop bit (exactly 4 clocks of stop), no idle gap.
- Write while busy: write 8'h11, then write 8'h22 while TxRdy=0.
  - 8'h22 is dropped; only 8'h11 is transmitted.
- Reset mid-frame: assert reset=0 during the 4th data bit.
  - Tx=1 and TxRdy=1 asynchronously.
  - After release, a write of 8'h3C transmits a clean frame.
- Even parity / macro check: ohel=0, pen=1, write 8'h03 → parity bit 0.
  - With UART_TX_TWO_STOP_EN defined: two stop-bit periods (2k clocks high) before the next start.
